// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the instruction cache
// Purpose: FSM state encoding and default geometry used by icache and its bench.
// Ports: none (package).
package icache_pkg;

  // Default index width: 2**8 = 256 one-word lines.
  localparam int IC_IDX_W = 8;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MISS = 2'd1,
    IC_DROP = 2'd2
  } ic_state_t;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch and memory-controller bus bundle for the instruction cache
// Purpose: groups the ifetch request/response and memory read handshake signals.
// Ports (signals):
//   if_addr     ifetch -> cache  fetch PC, bits [1:0] ignored
//   if_addr_sgn ifetch -> cache  request valid, level-held
//   if_ins_sgn  cache -> ifetch  one-cycle response pulse
//   if_ins      cache -> ifetch  instruction word
//   mc_req      cache -> mem     read request, held until mc_done
//   mc_addr     cache -> mem     word-aligned miss address
//   mc_done     mem -> cache     one-cycle data-valid pulse
//   mc_ins      mem -> cache     returned word
// Modports: master = ifetch/memory side, slave = cache side.
interface icache_if;

  logic [31:0] if_addr;
  logic        if_addr_sgn;
  logic        if_ins_sgn;
  logic [31:0] if_ins;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_ins;

  modport master (
    output if_addr, if_addr_sgn, mc_done, mc_ins,
    input  if_ins_sgn, if_ins, mc_req, mc_addr
  );

  modport slave (
    input  if_addr, if_addr_sgn, mc_done, mc_ins,
    output if_ins_sgn, if_ins, mc_req, mc_addr
  );

endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-line, read-only instruction cache
// Purpose: serves ifetch requests from a 2**IDX_W line cache and fills misses
//   from the memory controller; rollback drops pending responses.
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_rdy       global enable, low freezes all state
//   i_rollback  flush: abort current request / suppress miss response
//   bus         icache_if.slave: ifetch request/response and memory read bus
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = IC_IDX_W,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_rdy,
  input  logic    i_rollback,
  icache_if.slave bus
);

  localparam int LINES = 2 ** IDX_W;

  // Data and tag arrays carry no reset; only the valid bits must be cleared.
  logic [31:0]      r_data  [LINES];
  logic [TAG_W-1:0] r_tag   [LINES];
  logic [LINES-1:0] r_valid;

  ic_state_t   r_state;
  logic        r_ins_sgn;
  logic [31:0] r_ins;
  logic        r_mc_req;
  logic [31:0] r_mc_addr;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_hit;
  logic             w_fill;
  logic             w_accept;

  assign w_idx      = bus.if_addr[IDX_W+1:2];
  assign w_tag      = bus.if_addr[31:IDX_W+2];
  // The fill target comes from the latched miss address, since ifetch may
  // already have moved its PC (rollback, or dropping the request).
  assign w_fill_idx = r_mc_addr[IDX_W+1:2];
  assign w_fill_tag = r_mc_addr[31:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill     = ((r_state == IC_MISS) || (r_state == IC_DROP)) && bus.mc_done;
  // No acceptance during the response cycle: that bubble lets ifetch advance.
  assign w_accept   = bus.if_addr_sgn && !r_ins_sgn && !i_rollback;

  always_ff @(posedge i_clk) begin
    if (i_rdy && w_fill) begin
      r_data[w_fill_idx] <= bus.mc_ins;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IC_IDLE;
      r_valid   <= '0;
      r_ins_sgn <= 1'b0;
      r_ins     <= '0;
      r_mc_req  <= 1'b0;
      r_mc_addr <= '0;
    end else if (i_rdy) begin
      r_ins_sgn <= 1'b0;
      case (r_state)
        IC_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_ins     <= r_data[w_idx];
              r_ins_sgn <= 1'b1;
            end else begin
              r_mc_req  <= 1'b1;
              r_mc_addr <= bus.if_addr & ~32'h3;
              r_state   <= IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (bus.mc_done) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mc_req            <= 1'b0;
            r_state             <= IC_IDLE;
            if (!i_rollback) begin
              r_ins     <= bus.mc_ins;
              r_ins_sgn <= 1'b1;
            end
          end else if (i_rollback) begin
            // Memory transaction stays in flight; its data still fills the line.
            r_state <= IC_DROP;
          end
        end
        IC_DROP: begin
          if (bus.mc_done) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mc_req            <= 1'b0;
            r_state             <= IC_IDLE;
          end
        end
        default: r_state <= IC_IDLE;
      endcase
    end
  end

  assign bus.if_ins_sgn = r_ins_sgn;
  assign bus.if_ins     = r_ins;
  assign bus.mc_req     = r_mc_req;
  assign bus.mc_addr    = r_mc_addr;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache with a line-level reference model
module tb_icache;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;
  int   errors = 0;
  int   checks = 0;

  icache_if ifc ();

  icache dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rdy      (rdy),
    .i_rollback (rollback),
    .bus        (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: which word address each line holds, and its data.
  bit          m_valid [256];
  logic [29:0] m_word  [256];
  logic [31:0] m_data  [256];

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic bit predict_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_word[idx_of(a)] == a[31:2]);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
    m_valid[idx_of(a)] = 1'b1;
    m_word[idx_of(a)]  = a[31:2];
    m_data[idx_of(a)]  = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and serves a possible miss after lat wait cycles.
  // Returns observations only; callers compare them.
  task automatic fetch(input logic [31:0] a, input int lat, input logic [31:0] d,
                       output bit hit, output bit got, output logic [31:0] ins,
                       output logic [31:0] maddr, output bit req_held, output bit extra);
    hit = 0; got = 0; ins = '0; maddr = '0; req_held = 1; extra = 0;
    ifc.if_addr = a;
    ifc.if_addr_sgn = 1'b1;
    step();
    if (ifc.if_ins_sgn) begin
      hit = 1; got = 1; ins = ifc.if_ins;
    end else if (ifc.mc_req) begin
      maddr = ifc.mc_addr;
      for (int i = 0; i < lat; i++) begin
        step();
        if (!ifc.mc_req || ifc.if_ins_sgn) req_held = 0;
      end
      ifc.mc_done = 1'b1;
      ifc.mc_ins  = d;
      step();
      ifc.mc_done = 1'b0;
      got = ifc.if_ins_sgn;
      ins = ifc.if_ins;
    end
    step();
    extra = ifc.if_ins_sgn;
    ifc.if_addr_sgn = 1'b0;
  endtask

  task automatic test_reset();
    if (ifc.if_ins_sgn !== 1'b0) begin errors++; $display("FAIL reset_ins_sgn got=%0b exp=0", ifc.if_ins_sgn); end
    checks++;
    if (ifc.if_ins !== 32'h0) begin errors++; $display("FAIL reset_ins got=%h exp=0", ifc.if_ins); end
    checks++;
    if (ifc.mc_req !== 1'b0) begin errors++; $display("FAIL reset_mc_req got=%0b exp=0", ifc.mc_req); end
    checks++;
    if (ifc.mc_addr !== 32'h0) begin errors++; $display("FAIL reset_mc_addr got=%h exp=0", ifc.mc_addr); end
    checks++;
  endtask

  task automatic test_cold_miss();
    bit hit, got, held, extra;
    logic [31:0] ins, maddr;
    fetch(32'h4, 2, 32'h0040_0093, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b0) begin errors++; $display("FAIL cold_hit got=%0b exp=0", hit); end
    checks++;
    if (maddr !== 32'h4) begin errors++; $display("FAIL cold_mc_addr got=%h exp=00000004", maddr); end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL cold_req_held got=%0b exp=1", held); end
    checks++;
    if (got !== 1'b1 || ins !== 32'h0040_0093) begin
      errors++; $display("FAIL cold_resp got=%0b/%h exp=1/00400093", got, ins);
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL cold_bubble got=%0b exp=0", extra); end
    checks++;
    model_fill(32'h4, 32'h0040_0093);
  endtask

  task automatic test_hit();
    bit hit, got, held, extra;
    logic [31:0] ins, maddr;
    fetch(32'h4, 0, 32'hDEAD_BEEF, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b1 || ins !== 32'h0040_0093) begin
      errors++; $display("FAIL hit_resp got=%0b/%h exp=1/00400093", hit, ins);
    end
    checks++;
    if (ifc.mc_req !== 1'b0) begin errors++; $display("FAIL hit_mc_req got=%0b exp=0", ifc.mc_req); end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL hit_bubble got=%0b exp=0", extra); end
    checks++;
  endtask

  task automatic test_rollback_idle();
    ifc.if_addr = 32'h4;
    ifc.if_addr_sgn = 1'b1;
    rollback = 1'b1;
    step();
    if (ifc.if_ins_sgn !== 1'b0 || ifc.mc_req !== 1'b0) begin
      errors++; $display("FAIL rb_idle_blocked got=%0b/%0b exp=0/0", ifc.if_ins_sgn, ifc.mc_req);
    end
    checks++;
    rollback = 1'b0;
    step();
    if (ifc.if_ins_sgn !== 1'b1 || ifc.if_ins !== m_data[1]) begin
      errors++; $display("FAIL rb_idle_after got=%0b/%h exp=1/%h", ifc.if_ins_sgn, ifc.if_ins, m_data[1]);
    end
    checks++;
    ifc.if_addr_sgn = 1'b0;
    step();
  endtask

  task automatic test_conflict();
    bit hit, got, held, extra;
    logic [31:0] ins, maddr;
    fetch(32'h404, 1, 32'hA5A5_0404, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b0 || maddr !== 32'h404) begin
      errors++; $display("FAIL conflict_miss got=%0b/%h exp=0/00000404", hit, maddr);
    end
    checks++;
    if (got !== 1'b1 || ins !== 32'hA5A5_0404) begin
      errors++; $display("FAIL conflict_resp got=%0b/%h exp=1/a5a50404", got, ins);
    end
    checks++;
    model_fill(32'h404, 32'hA5A5_0404);
    fetch(32'h4, 0, 32'h0040_0093, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b0 || maddr !== 32'h4 || ins !== 32'h0040_0093) begin
      errors++; $display("FAIL conflict_refetch got=%0b/%h/%h exp=0/00000004/00400093", hit, maddr, ins);
    end
    checks++;
    model_fill(32'h4, 32'h0040_0093);
  endtask

  task automatic test_rollback_miss();
    bit hit, got, held, extra;
    logic [31:0] ins, maddr;
    ifc.if_addr = 32'h10;
    ifc.if_addr_sgn = 1'b1;
    step();
    if (ifc.mc_req !== 1'b1) begin errors++; $display("FAIL rb_miss_req got=%0b exp=1", ifc.mc_req); end
    checks++;
    step();
    rollback = 1'b1;
    ifc.if_addr_sgn = 1'b0;
    step();
    rollback = 1'b0;
    if (ifc.mc_req !== 1'b1 || ifc.if_ins_sgn !== 1'b0) begin
      errors++; $display("FAIL rb_miss_held1 got=%0b/%0b exp=1/0", ifc.mc_req, ifc.if_ins_sgn);
    end
    checks++;
    step();
    if (ifc.mc_req !== 1'b1 || ifc.if_ins_sgn !== 1'b0) begin
      errors++; $display("FAIL rb_miss_held2 got=%0b/%0b exp=1/0", ifc.mc_req, ifc.if_ins_sgn);
    end
    checks++;
    ifc.mc_done = 1'b1;
    ifc.mc_ins  = 32'h1111_0010;
    step();
    ifc.mc_done = 1'b0;
    if (ifc.mc_req !== 1'b0 || ifc.if_ins_sgn !== 1'b0) begin
      errors++; $display("FAIL rb_miss_done got=%0b/%0b exp=0/0", ifc.mc_req, ifc.if_ins_sgn);
    end
    checks++;
    model_fill(32'h10, 32'h1111_0010);
    fetch(32'h10, 0, 32'hDEAD_0010, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b1 || ins !== 32'h1111_0010) begin
      errors++; $display("FAIL rb_miss_rehit got=%0b/%h exp=1/11110010", hit, ins);
    end
    checks++;
    // Rollback coinciding with the memory reply.
    ifc.if_addr = 32'h20;
    ifc.if_addr_sgn = 1'b1;
    step();
    ifc.mc_done = 1'b1;
    ifc.mc_ins  = 32'h2222_0020;
    rollback = 1'b1;
    ifc.if_addr_sgn = 1'b0;
    step();
    ifc.mc_done = 1'b0;
    rollback = 1'b0;
    if (ifc.mc_req !== 1'b0 || ifc.if_ins_sgn !== 1'b0) begin
      errors++; $display("FAIL rb_same_cycle got=%0b/%0b exp=0/0", ifc.mc_req, ifc.if_ins_sgn);
    end
    checks++;
    model_fill(32'h20, 32'h2222_0020);
    fetch(32'h20, 0, 32'hDEAD_0020, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b1 || ins !== 32'h2222_0020) begin
      errors++; $display("FAIL rb_same_rehit got=%0b/%h exp=1/22220020", hit, ins);
    end
    checks++;
  endtask

  task automatic test_rdy_freeze();
    ifc.if_addr = 32'h30;
    ifc.if_addr_sgn = 1'b1;
    step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // A done pulse while frozen must not be sampled.
      ifc.mc_done = (i == 1);
      ifc.mc_ins  = 32'hBAD0_BAD0;
      step();
      ifc.mc_done = 1'b0;
      if (ifc.mc_req !== 1'b1 || ifc.mc_addr !== 32'h30 || ifc.if_ins_sgn !== 1'b0) begin
        errors++; $display("FAIL freeze_hold%0d got=%0b/%h/%0b exp=1/00000030/0", i, ifc.mc_req, ifc.mc_addr, ifc.if_ins_sgn);
      end
      checks++;
    end
    rdy = 1'b1;
    step();
    if (ifc.mc_req !== 1'b1) begin errors++; $display("FAIL freeze_resume_req got=%0b exp=1", ifc.mc_req); end
    checks++;
    ifc.mc_done = 1'b1;
    ifc.mc_ins  = 32'h3333_0030;
    step();
    ifc.mc_done = 1'b0;
    if (ifc.if_ins_sgn !== 1'b1 || ifc.if_ins !== 32'h3333_0030) begin
      errors++; $display("FAIL freeze_resp got=%0b/%h exp=1/33330030", ifc.if_ins_sgn, ifc.if_ins);
    end
    checks++;
    step();
    ifc.if_addr_sgn = 1'b0;
    model_fill(32'h30, 32'h3333_0030);
  endtask

  task automatic test_random();
    bit hit, got, held, extra, exp_hit;
    logic [31:0] ins, maddr, a, exp_d;
    logic [31:0] tags [3];
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h002A_BCDE;
    for (int n = 0; n < 40; n++) begin
      a = (tags[$urandom_range(0, 2)] << 10) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      exp_hit = predict_hit(a);
      exp_d = exp_hit ? m_data[idx_of(a)] : mem_word(a);
      fetch(a, $urandom_range(0, 3), mem_word(a), hit, got, ins, maddr, held, extra);
      if (hit !== exp_hit || got !== 1'b1 || ins !== exp_d) begin
        errors++; $display("FAIL rand%0d_resp addr=%h got=%0b/%0b/%h exp=%0b/1/%h", n, a, hit, got, ins, exp_hit, exp_d);
      end
      checks++;
      if (!exp_hit) begin
        if (maddr !== {a[31:2], 2'b00} || held !== 1'b1) begin
          errors++; $display("FAIL rand%0d_miss got=%h/%0b exp=%h/1", n, maddr, held, {a[31:2], 2'b00});
        end
        checks++;
        model_fill(a, mem_word(a));
      end
      if (extra !== 1'b0) begin errors++; $display("FAIL rand%0d_bubble got=%0b exp=0", n, extra); end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    bit hit, got, held, extra;
    logic [31:0] ins, maddr;
    ifc.if_addr = 32'h40;
    ifc.if_addr_sgn = 1'b1;
    step();
    if (ifc.mc_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req got=%0b exp=1", ifc.mc_req); end
    checks++;
    step();
    ifc.if_addr_sgn = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (ifc.mc_req !== 1'b0 || ifc.if_ins_sgn !== 1'b0 || ifc.mc_addr !== 32'h0) begin
      errors++; $display("FAIL areset_now got=%0b/%0b/%h exp=0/0/0", ifc.mc_req, ifc.if_ins_sgn, ifc.mc_addr);
    end
    checks++;
    #3 rst = 1'b0;
    model_clear();
    fetch(32'h10, 1, 32'h4444_0010, hit, got, ins, maddr, held, extra);
    if (hit !== 1'b0 || maddr !== 32'h10 || ins !== 32'h4444_0010) begin
      errors++; $display("FAIL areset_cold got=%0b/%h/%h exp=0/00000010/44440010", hit, maddr, ins);
    end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rollback = 1'b0;
    ifc.if_addr = '0;
    ifc.if_addr_sgn = 1'b0;
    ifc.mc_done = 1'b0;
    ifc.mc_ins = '0;
    model_clear();
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_cold_miss();
    test_hit();
    test_rollback_idle();
    test_conflict();
    test_rollback_miss();
    test_rdy_freeze();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
